// File: rtl/fault_pkg.sv
// Shared fault-tracking types: cause codes, default widths, saturating counter helper.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package fault_pkg;

  localparam int DEFAULT_CAUSEW = 3;
  localparam int MIN_DEPTH      = 2;
  localparam int MAX_DEPTH      = 8;

  // Cause codes as presented by the MMU alongside fault_valid.
  typedef enum logic [DEFAULT_CAUSEW-1:0] {
    FC_NONE   = 3'd0,
    FC_UNDEF  = 3'd1,
    FC_PABORT = 3'd2,
    FC_DABORT = 3'd3,
    FC_SWI    = 3'd4
  } fault_cause_t;

  // Event counters stick at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fault_tracker_if.sv
// Bundle between pipeline control/MMU and the fault tracker.
// Latency: none (wiring only).
// Backpressure: per-stage Stall/Flush vectors travel here; outputs are tracker status.
interface fault_tracker_if #(
  parameter int DEPTH  = 2,
  parameter int CAUSEW = 3,
  parameter int ADDRW  = 32
);

  logic              fault_valid;
  logic [CAUSEW-1:0] fault_cause;
  logic [ADDRW-1:0]  fault_addr;
  logic [DEPTH-1:0]  Stall;
  logic [DEPTH-1:0]  Flush;

  logic              FaultTake;
  logic [CAUSEW-1:0] TakeCause;
  logic [ADDRW-1:0]  TakeAddr;
  logic              FaultSquashed;
  logic [DEPTH-1:0]  StageValid;

  // Pipeline/MMU side: drives fault capture and stage control, observes status.
  modport master (
    output fault_valid, fault_cause, fault_addr, Stall, Flush,
    input  FaultTake, TakeCause, TakeAddr, FaultSquashed, StageValid
  );

  // Tracker side.
  modport slave (
    input  fault_valid, fault_cause, fault_addr, Stall, Flush,
    output FaultTake, TakeCause, TakeAddr, FaultSquashed, StageValid
  );

endinterface

// File: rtl/fault_stage.sv
// One pipeline slot holding {valid, cause, addr} for a possible faulting instruction.
// Latency: one cycle from in_* to valid/cause/addr.
// Backpressure: kill beats hold, hold beats bubble, bubble beats load.
module fault_stage #(
  parameter int CAUSEW = 3,
  parameter int ADDRW  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              kill,
  input  logic              hold,
  input  logic              bubble,
  input  logic              in_valid,
  input  logic [CAUSEW-1:0] in_cause,
  input  logic [ADDRW-1:0]  in_addr,
  output logic              valid,
  output logic [CAUSEW-1:0] cause,
  output logic [ADDRW-1:0]  addr
);

  // Slot update; any entry that is not a live fault carries zero cause/addr
  // so downstream outputs never expose stale payload.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      cause <= '0;
      addr  <= '0;
    end else if (kill) begin
      valid <= 1'b0;
      cause <= '0;
      addr  <= '0;
    end else if (hold) begin
      valid <= valid;
      cause <= cause;
      addr  <= addr;
    end else if (bubble) begin
      valid <= 1'b0;
      cause <= '0;
      addr  <= '0;
    end else begin
      valid <= in_valid;
      cause <= in_valid ? in_cause : '0;
      addr  <= in_valid ? in_addr  : '0;
    end
  end

endmodule

// File: rtl/fault_tracker.sv
// Tracks MMU faults down a DEPTH-stage pipeline to the take stage; optional counters under FAULT_TRACKER_STATS_EN.
// Latency: DEPTH-1 cycles from stage-0 capture to FaultTake, plus one per stalled cycle; Take* outputs are registered.
// Backpressure: Stall holds a stage and bubbles the next; Flush kills its stage and all younger ones, reported on FaultSquashed.
module fault_tracker
  import fault_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int CAUSEW = DEFAULT_CAUSEW,
  parameter int ADDRW  = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  fault_tracker_if.slave     bus
`ifdef FAULT_TRACKER_STATS_EN
  ,
  output logic [15:0]        SquashCount,
  output logic [15:0]        TakeCount
`endif
);

  logic [DEPTH-1:0]  kill;
  logic [DEPTH-1:0]  stage_valid;
  logic [CAUSEW-1:0] stage_cause [DEPTH];
  logic [ADDRW-1:0]  stage_addr  [DEPTH];

  // A flush at stage j kills stage j and every younger (lower-index) stage.
  for (genvar k = 0; k < DEPTH; k++) begin : g_kill
    assign kill[k] = |bus.Flush[DEPTH-1:k];
  end

  // Stage 0 captures from the MMU; later stages shift from their predecessor,
  // taking a bubble when the predecessor is stalled.
  for (genvar g = 0; g < DEPTH; g++) begin : g_stage
    logic              in_valid;
    logic [CAUSEW-1:0] in_cause;
    logic [ADDRW-1:0]  in_addr;
    logic              bubble;

    if (g == 0) begin : g_head
      assign in_valid = bus.fault_valid;
      assign in_cause = bus.fault_cause;
      assign in_addr  = bus.fault_addr;
      assign bubble   = 1'b0;
    end else begin : g_body
      assign in_valid = stage_valid[g-1];
      assign in_cause = stage_cause[g-1];
      assign in_addr  = stage_addr[g-1];
      assign bubble   = bus.Stall[g-1];
    end

    fault_stage #(
      .CAUSEW (CAUSEW),
      .ADDRW  (ADDRW)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .kill     (kill[g]),
      .hold     (bus.Stall[g]),
      .bubble   (bubble),
      .in_valid (in_valid),
      .in_cause (in_cause),
      .in_addr  (in_addr),
      .valid    (stage_valid[g]),
      .cause    (stage_cause[g]),
      .addr     (stage_addr[g])
    );
  end

  // Take-stage outputs come straight from flops; only FaultSquashed sees Flush
  // combinationally. An incoming fault never counts as squashed since it is
  // not yet in any stage.
  assign bus.FaultTake     = stage_valid[DEPTH-1];
  assign bus.TakeCause     = stage_cause[DEPTH-1];
  assign bus.TakeAddr      = stage_addr[DEPTH-1];
  assign bus.StageValid    = stage_valid;
  assign bus.FaultSquashed = |(stage_valid & kill);

`ifdef FAULT_TRACKER_STATS_EN
  logic squash_evt;
  logic take_evt;

  assign squash_evt = |(stage_valid & kill);
  assign take_evt   = stage_valid[DEPTH-1] & ~bus.Stall[DEPTH-1] & ~bus.Flush[DEPTH-1];

  // One count per squash cycle however many entries die; one per retired take.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      SquashCount <= '0;
      TakeCount   <= '0;
    end else begin
      if (squash_evt) SquashCount <= sat_inc16(SquashCount);
      if (take_evt)   TakeCount   <= sat_inc16(TakeCount);
    end
  end
`endif

endmodule

// File: tb/tb_fault_tracker.sv
// Directed bench for fault_tracker at DEPTH=2 and DEPTH=4.
// Latency: checks registered outputs 1 time unit after each rising edge.
// Backpressure: exercises Stall/Flush vectors directly.
module tb_fault_tracker;
  import fault_pkg::*;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  fault_tracker_if #(.DEPTH(2), .CAUSEW(3), .ADDRW(32)) if2 ();
  fault_tracker_if #(.DEPTH(4), .CAUSEW(3), .ADDRW(32)) if4 ();

`ifdef FAULT_TRACKER_STATS_EN
  logic [15:0] sq2, tk2, sq4, tk4;
`endif

  fault_tracker #(.DEPTH(2), .CAUSEW(3), .ADDRW(32)) d2 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if2)
`ifdef FAULT_TRACKER_STATS_EN
    , .SquashCount (sq2), .TakeCount (tk2)
`endif
  );

  fault_tracker #(.DEPTH(4), .CAUSEW(3), .ADDRW(32)) d4 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (if4)
`ifdef FAULT_TRACKER_STATS_EN
    , .SquashCount (sq4), .TakeCount (tk4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if2.fault_valid = 1'b0; if2.fault_cause = '0; if2.fault_addr = '0;
    if2.Stall = '0; if2.Flush = '0;
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0;
    if4.Stall = '0; if4.Flush = '0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle_inputs();
    #2;
    checks++; if (if2.StageValid !== 2'b00 || if2.FaultTake !== 1'b0) begin
      errors++; $display("FAIL reset_d2 sv=%b take=%b want sv=00 take=0", if2.StageValid, if2.FaultTake); end
    checks++; if (if4.StageValid !== 4'b0000 || if4.FaultSquashed !== 1'b0) begin
      errors++; $display("FAIL reset_d4 sv=%b sq=%b want sv=0000 sq=0", if4.StageValid, if4.FaultSquashed); end
    checks++; if (if4.TakeCause !== 3'd0 || if4.TakeAddr !== 32'd0) begin
      errors++; $display("FAIL reset_take_payload cause=%0d addr=%h want 0/0", if4.TakeCause, if4.TakeAddr); end
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    if2.fault_valid = 1'b1; if2.fault_cause = FC_UNDEF; if2.fault_addr = 32'h1000;
    tick();
    if2.fault_valid = 1'b0; if2.fault_cause = '0; if2.fault_addr = '0;
    checks++; if (if2.StageValid !== 2'b01 || if2.FaultTake !== 1'b0) begin
      errors++; $display("FAIL basic_capture sv=%b take=%b want sv=01 take=0", if2.StageValid, if2.FaultTake); end
    tick();
    checks++; if (if2.FaultTake !== 1'b1 || if2.TakeCause !== 3'd1 || if2.TakeAddr !== 32'h1000) begin
      errors++; $display("FAIL basic_take take=%b cause=%0d addr=%h want 1/1/00001000", if2.FaultTake, if2.TakeCause, if2.TakeAddr); end
    tick();
    checks++; if (if2.FaultTake !== 1'b0 || if2.TakeCause !== 3'd0 || if2.TakeAddr !== 32'd0) begin
      errors++; $display("FAIL basic_retire take=%b cause=%0d addr=%h want 0/0/0", if2.FaultTake, if2.TakeCause, if2.TakeAddr); end
  endtask

  task automatic test_stall();
    if4.fault_valid = 1'b1; if4.fault_cause = FC_DABORT; if4.fault_addr = 32'h2000;
    tick();
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0;
    checks++; if (if4.StageValid !== 4'b0001) begin
      errors++; $display("FAIL stall_capture sv=%b want 0001", if4.StageValid); end
    tick();
    checks++; if (if4.StageValid !== 4'b0010) begin
      errors++; $display("FAIL stall_s1 sv=%b want 0010", if4.StageValid); end
    if4.Stall = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (if4.StageValid !== 4'b0010 || if4.FaultTake !== 1'b0) begin
        errors++; $display("FAIL stall_hold_%0d sv=%b take=%b want sv=0010 take=0", i, if4.StageValid, if4.FaultTake); end
    end
    if4.Stall = 4'b0000;
    tick();
    checks++; if (if4.StageValid !== 4'b0100 || if4.FaultTake !== 1'b0) begin
      errors++; $display("FAIL stall_s2 sv=%b take=%b want sv=0100 take=0", if4.StageValid, if4.FaultTake); end
    tick();
    checks++; if (if4.FaultTake !== 1'b1 || if4.TakeCause !== 3'd3 || if4.TakeAddr !== 32'h2000) begin
      errors++; $display("FAIL stall_take take=%b cause=%0d addr=%h want 1/3/00002000", if4.FaultTake, if4.TakeCause, if4.TakeAddr); end
    tick();
    checks++; if (if4.FaultTake !== 1'b0) begin
      errors++; $display("FAIL stall_retire take=%b want 0", if4.FaultTake); end
  endtask

  task automatic test_squash();
    if4.fault_valid = 1'b1; if4.fault_cause = FC_PABORT; if4.fault_addr = 32'h3000;
    tick();
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0;
    tick();
    checks++; if (if4.StageValid !== 4'b0010) begin
      errors++; $display("FAIL squash_s1 sv=%b want 0010", if4.StageValid); end
    if4.Flush = 4'b0100;
    #1;
    checks++; if (if4.FaultSquashed !== 1'b1) begin
      errors++; $display("FAIL squash_pulse sq=%b want 1", if4.FaultSquashed); end
    tick();
    if4.Flush = 4'b0000;
    #1;
    checks++; if (if4.StageValid !== 4'b0000 || if4.FaultSquashed !== 1'b0) begin
      errors++; $display("FAIL squash_after sv=%b sq=%b want sv=0000 sq=0", if4.StageValid, if4.FaultSquashed); end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++; if (if4.FaultTake !== 1'b0) begin
        errors++; $display("FAIL squash_no_take_%0d take=%b want 0", i, if4.FaultTake); end
    end
  endtask

  task automatic test_stall_flush0();
    // Fault offered while stage 0 is stalled is ignored.
    if4.fault_valid = 1'b1; if4.fault_cause = FC_SWI; if4.fault_addr = 32'h5000;
    if4.Stall = 4'b0001;
    tick();
    checks++; if (if4.StageValid !== 4'b0000) begin
      errors++; $display("FAIL stall0_ignore sv=%b want 0000", if4.StageValid); end
    if4.Stall = 4'b0000;
    tick();
    checks++; if (if4.StageValid !== 4'b0001) begin
      errors++; $display("FAIL stall0_recapture sv=%b want 0001", if4.StageValid); end
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0;
    if4.Stall = 4'b0001; if4.Flush = 4'b0001;
    #1;
    checks++; if (if4.FaultSquashed !== 1'b1) begin
      errors++; $display("FAIL flush0_pulse sq=%b want 1", if4.FaultSquashed); end
    tick();
    if4.Stall = 4'b0000; if4.Flush = 4'b0000;
    checks++; if (if4.StageValid !== 4'b0000) begin
      errors++; $display("FAIL flush0_clear sv=%b want 0000", if4.StageValid); end
    // Incoming fault together with Flush[0]: no capture, no squash report.
    if4.fault_valid = 1'b1; if4.fault_cause = FC_UNDEF; if4.fault_addr = 32'h6000;
    if4.Flush = 4'b0001;
    #1;
    checks++; if (if4.FaultSquashed !== 1'b0) begin
      errors++; $display("FAIL incoming_flush_sq sq=%b want 0", if4.FaultSquashed); end
    tick();
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0; if4.Flush = 4'b0000;
    checks++; if (if4.StageValid !== 4'b0000) begin
      errors++; $display("FAIL incoming_flush_cap sv=%b want 0000", if4.StageValid); end
  endtask

  task automatic test_back_to_back();
    if4.fault_valid = 1'b1; if4.fault_cause = FC_UNDEF;  if4.fault_addr = 32'h100;
    tick();
    if4.fault_cause = FC_PABORT; if4.fault_addr = 32'h200;
    tick();
    if4.fault_cause = FC_DABORT; if4.fault_addr = 32'h300;
    tick();
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0;
    checks++; if (if4.StageValid !== 4'b0111) begin
      errors++; $display("FAIL b2b_fill sv=%b want 0111", if4.StageValid); end
    for (int k = 1; k <= 3; k++) begin
      tick();
      checks++; if (if4.FaultTake !== 1'b1 || if4.TakeCause !== 3'(k) || if4.TakeAddr !== 32'(k * 32'h100)) begin
        errors++; $display("FAIL b2b_take_%0d take=%b cause=%0d addr=%h want 1/%0d/%h", k, if4.FaultTake, if4.TakeCause, if4.TakeAddr, k, k * 32'h100); end
    end
    tick();
    checks++; if (if4.FaultTake !== 1'b0) begin
      errors++; $display("FAIL b2b_end take=%b want 0", if4.FaultTake); end
  endtask

  task automatic test_reset_midflight();
`ifdef FAULT_TRACKER_STATS_EN
    checks++; if (sq4 !== 16'd2 || tk4 !== 16'd4 || tk2 !== 16'd1) begin
      errors++; $display("FAIL stats_pre sq4=%0d tk4=%0d tk2=%0d want 2/4/1", sq4, tk4, tk2); end
`endif
    if4.fault_valid = 1'b1; if4.fault_cause = FC_UNDEF; if4.fault_addr = 32'h700;
    tick();
    if4.fault_cause = FC_PABORT; if4.fault_addr = 32'h800;
    tick();
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0;
    checks++; if (if4.StageValid !== 4'b0011) begin
      errors++; $display("FAIL midrst_fill sv=%b want 0011", if4.StageValid); end
    reset_n = 1'b0;
    if4.Flush = 4'b1111;
    #1;
    checks++; if (if4.StageValid !== 4'b0000 || if4.FaultTake !== 1'b0 || if4.FaultSquashed !== 1'b0) begin
      errors++; $display("FAIL midrst_outputs sv=%b take=%b sq=%b want 0000/0/0", if4.StageValid, if4.FaultTake, if4.FaultSquashed); end
`ifdef FAULT_TRACKER_STATS_EN
    checks++; if (sq4 !== 16'd0 || tk4 !== 16'd0) begin
      errors++; $display("FAIL midrst_stats sq4=%0d tk4=%0d want 0/0", sq4, tk4); end
`endif
    tick();
    if4.Flush = 4'b0000;
    reset_n = 1'b1;
    if4.fault_valid = 1'b1; if4.fault_cause = FC_SWI; if4.fault_addr = 32'h4000;
    tick();
    if4.fault_valid = 1'b0; if4.fault_cause = '0; if4.fault_addr = '0;
    checks++; if (if4.StageValid !== 4'b0001) begin
      errors++; $display("FAIL midrst_resume sv=%b want 0001", if4.StageValid); end
    repeat (5) tick();
  endtask

`ifdef FAULT_TRACKER_STATS_EN
  task automatic test_saturation();
    if2.fault_valid = 1'b1; if2.fault_cause = FC_UNDEF; if2.fault_addr = 32'h9000;
    tick();
    tick();
    for (int i = 0; i < 70000; i++) begin
      if2.Flush = 2'b10;
      tick();
      if2.Flush = 2'b00;
      tick();
    end
    if2.fault_valid = 1'b0;
    checks++; if (sq2 !== 16'hFFFF) begin
      errors++; $display("FAIL squash_saturate sq2=%h want ffff", sq2); end
  endtask
`endif

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_basic();
    test_stall();
    test_squash();
    test_stall_flush0();
    test_back_to_back();
    repeat (3) tick();
    test_reset_midflight();
`ifdef FAULT_TRACKER_STATS_EN
    test_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fault_tracker.md
FAULT_TRACKER -- requirements
Module: fault_tracker

Interface
REQ-001 SHALL have parameter DEPTH, default 2, number of tracked stages; stage 0 is Decode, stage DEPTH-1 is the take stage; legal range 2..8.
REQ-002 SHALL have parameter CAUSEW, default 3, fault cause width.
REQ-003 SHALL have parameter ADDRW, default 32, faulting address width.
REQ-004 SHALL have port clk  in  1  rising-edge clock; the block uses one clock.
REQ-005 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port fault_valid  in  1  MMU flags the instruction entering stage 0 as faulting.
REQ-007 SHALL have port fault_cause  in  CAUSEW  cause code qualified by fault_valid.
REQ-008 SHALL have port fault_addr  in  ADDRW  faulting address qualified by fault_valid.
REQ-009 SHALL have port Stall  in  DEPTH  per-stage stall, bit 0 = Decode.
REQ-010 SHALL have port Flush  in  DEPTH  per-stage flush, bit 0 = Decode.
REQ-011 SHALL have port FaultTake  out  1  a live fault occupies the take stage.
REQ-012 SHALL have port TakeCause  out  CAUSEW  cause of the take-stage entry; 0 when FaultTake=0.
REQ-013 SHALL have port TakeAddr  out  ADDRW  address of the take-stage entry; 0 when FaultTake=0.
REQ-014 SHALL have port FaultSquashed  out  1  a live fault is discarded by a flush this cycle.
REQ-015 SHALL have port StageValid  out  DEPTH  per-stage live-fault vector.

Function
REQ-016 SHALL define kill[i] = OR of Flush[j] for j>=i, so a flush kills its own stage and every younger stage.
REQ-017 SHALL update stage 0 with the following priority: kill[0] clears it; else Stall[0] holds it; else it loads {fault_valid, fault_cause, fault_addr}.
REQ-018 SHALL update stage i>0 with the following priority: kill[i] clears it; else Stall[i] holds it; else Stall[i-1] inserts a bubble (valid=0); else it loads stage i-1.
REQ-019 SHALL give Flush priority over Stall at the same stage.
REQ-020 SHALL zero the cause and address of a cleared or bubbled entry.
REQ-021 SHALL drive FaultTake = StageValid[DEPTH-1], registered with no combinational path from inputs; TakeCause and TakeAddr are registered likewise.
REQ-022 SHALL give a fault a minimum latency of DEPTH-1 cycles from capture at stage 0 to FaultTake; each stalled cycle adds one.
REQ-023 SHALL hold FaultTake high while Stall[DEPTH-1]=1 and Flush[DEPTH-1]=0.
REQ-024 SHALL retire a take-stage entry when Stall[DEPTH-1]=0, leaving no trace after it retires.
REQ-025 SHALL compute FaultSquashed combinationally as OR over i of StageValid[i] & kill[i].
REQ-026 SHALL ignore fault_valid while Stall[0]=1; the MMU re-presents the fault.
REQ-027 SHALL allow multiple faults in flight, one per stage, each tracked independently.
REQ-028 SHALL, when fault_valid and Flush[0] are both high, capture nothing, and SHALL NOT assert FaultSquashed for that incoming fault.

Reset
REQ-029 SHALL, while reset_n=0, clear all stage valids, causes and addresses (and counters, when present) asynchronously.
REQ-030 SHALL drive FaultTake=0, TakeCause=0, TakeAddr=0, StageValid=0 and FaultSquashed=0 while reset_n=0.
REQ-031 SHALL, on reset mid-operation, discard in-flight faults with no FaultSquashed pulse.
REQ-032 SHALL resume capture on the first rising edge after reset_n deasserts.

Configuration
REQ-033 SHALL, with FAULT_TRACKER_STATS_EN defined, add outputs SquashCount[15:0] and TakeCount[15:0], both saturating at 16'hFFFF.
REQ-034 SHALL increment SquashCount by one per cycle in which FaultSquashed=1, regardless of how many entries are killed that cycle.
REQ-035 SHALL increment TakeCount when FaultTake & ~Stall[DEPTH-1] & ~Flush[DEPTH-1].
REQ-036 SHALL, without FAULT_TRACKER_STATS_EN, omit both count ports and their logic entirely.

Structure
REQ-037 SHALL place in shared package fault_pkg: the cause typedef fault_cause_t, cause constants (FC_NONE=0, FC_UNDEF=1, FC_PABORT=2, FC_DABORT=3, FC_SWI=4), and a DEFAULT_CAUSEW constant.
REQ-038 SHALL implement one stage slot as sub-module fault_stage (with kill/hold/bubble/load priority), instantiated DEPTH times by a generate loop.

Verification
REQ-039 SHALL cover: DEPTH=2, fault_valid=1, cause=1, addr=0x1000 for one cycle with no stalls -> FaultTake=1, TakeCause=1, TakeAddr=0x1000 exactly one cycle later, for one cycle.
REQ-040 SHALL cover: DEPTH=4, fault captured, then Stall[1]=1 for 3 cycles -> FaultTake asserts 6 cycles after capture (3+3); stage 2 shows bubbles during the stall.
REQ-041 SHALL cover: DEPTH=4, fault in stage 1, Flush[2]=1 -> FaultSquashed=1 in that cycle; StageValid=0 next cycle; FaultTake never rises.
REQ-042 SHALL cover: Stall[0]=1 and Flush[0]=1 with a live stage-0 fault -> entry cleared, FaultSquashed=1.
REQ-043 SHALL cover: faults on 3 consecutive cycles with causes 1, 2, 3, DEPTH=4 -> FaultTake high for 3 consecutive cycles with causes 1, 2, 3 in order.
REQ-044 SHALL cover: reset_n=0 with 2 faults in flight -> all outputs 0 immediately; with FAULT_TRACKER_STATS_EN, counts 0; then 70000 squashes -> SquashCount=0xFFFF.
